// File: rtl/window_3x3_gen.sv
// window_3x3_gen
// Streaming 3x3 neighbourhood generator for 12-bit RGB444 pixels in raster order.
// Two line buffers hold the previous two rows; three column stages hold the last
// three columns of the neighbourhood. Each accepted pixel updates the registered
// 108-bit window; only interior positions raise window_valid.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   pixel_in     in   RGB444 pixel {R[11:8], G[7:4], B[3:0]}
//   pixel_valid  in   pixel_in accepted on this edge when high
//   frame_start  in   qualified by pixel_valid; pixel_in is pixel (0,0)
//   color_data   out  3x3 window, centre in [107:96] down to downright in [11:0]
//   window_valid out  single-cycle pulse: color_data holds a new interior window
//   out_x        out  centre column of the current window
//   out_y        out  centre row of the current window
module window_3x3_gen #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [11:0]                   pixel_in,
  input  logic                          pixel_valid,
  input  logic                          frame_start,
  output logic [107:0]                  color_data,
  output logic                          window_valid,
  output logic [$clog2(IMG_WIDTH)-1:0]  out_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] out_y
);

  localparam int unsigned XW = $clog2(IMG_WIDTH);
  localparam int unsigned YW = $clog2(IMG_HEIGHT);

  // Position of the next accepted pixel
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  // Column stages, each {top (row y-2), mid (row y-1), bot (row y)}.
  // r_col0 is the oldest (leftmost) column, r_col2 the newest (rightmost).
  logic [35:0] r_col0;
  logic [35:0] r_col1;
  logic [35:0] r_col2;

  logic          r_window_valid;
  logic [XW-1:0] r_out_x;
  logic [YW-1:0] r_out_y;

  // Line buffers: lb0 holds row y-1, lb1 holds row y-2; contents are not reset
  logic [11:0] r_lb0 [IMG_WIDTH];
  logic [11:0] r_lb1 [IMG_WIDTH];

  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic          w_last_x;
  logic          w_last_y;
  logic          w_interior;
  logic [11:0]   w_lb0_rd;
  logic [11:0]   w_lb1_rd;

  // frame_start forces the accepted pixel to (0,0) whatever the counters say
  assign w_x        = frame_start ? '0 : r_x;
  assign w_y        = frame_start ? '0 : r_y;
  assign w_last_x   = (w_x == XW'(IMG_WIDTH - 1));
  assign w_last_y   = (w_y == YW'(IMG_HEIGHT - 1));
  assign w_interior = (w_x >= XW'(2)) && (w_y >= YW'(2));

  assign w_lb0_rd = r_lb0[w_x];
  assign w_lb1_rd = r_lb1[w_x];

  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      r_lb1[w_x] <= w_lb0_rd;
      r_lb0[w_x] <= pixel_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x            <= '0;
      r_y            <= '0;
      r_col0         <= '0;
      r_col1         <= '0;
      r_col2         <= '0;
      r_window_valid <= 1'b0;
      r_out_x        <= '0;
      r_out_y        <= '0;
    end else begin
      r_window_valid <= pixel_valid && w_interior;
      if (pixel_valid) begin
        if (w_last_x) begin
          r_x <= '0;
          r_y <= w_last_y ? '0 : w_y + YW'(1);
        end else begin
          r_x <= w_x + XW'(1);
          r_y <= w_y;
        end
        r_col0 <= r_col1;
        r_col1 <= r_col2;
        r_col2 <= {w_lb1_rd, w_lb0_rd, pixel_in};
        if (w_interior) begin
          r_out_x <= w_x - XW'(1);
          r_out_y <= w_y - YW'(1);
        end
      end
    end
  end

  // Window bus is pure wiring from the column stages, so it is registered with them
  assign color_data = {
    r_col1[23:12],  // centre
    r_col0[23:12],  // left
    r_col2[23:12],  // right
    r_col1[35:24],  // up
    r_col1[11:0],   // down
    r_col0[35:24],  // upleft
    r_col2[35:24],  // upright
    r_col0[11:0],   // downleft
    r_col2[11:0]    // downright
  };

  assign window_valid = r_window_valid;
  assign out_x        = r_out_x;
  assign out_y        = r_out_y;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Self-checking bench for window_3x3_gen. A 4x3 instance runs the directed
// scenarios with literal expectations; a default 640x480 instance runs random
// pixels. A frame-memory reference model checks both on every cycle.
module tb_window_3x3_gen;

  localparam logic [107:0] P1 = {12'h011, 12'h010, 12'h012, 12'h001, 12'h021,
                                 12'h000, 12'h002, 12'h020, 12'h022};
  localparam logic [107:0] P2 = {12'h012, 12'h011, 12'h013, 12'h002, 12'h022,
                                 12'h001, 12'h003, 12'h021, 12'h023};

  logic clk = 1'b0;
  logic rst_n;

  // Small 4x3 instance
  logic [11:0]  s_pix;
  logic         s_pv;
  logic         s_fs;
  logic [107:0] s_cd;
  logic         s_wv;
  logic [1:0]   s_ox;
  logic [1:0]   s_oy;

  // Default 640x480 instance
  logic [11:0]  d_pix;
  logic         d_pv;
  logic         d_fs;
  logic [107:0] d_cd;
  logic         d_wv;
  logic [9:0]   d_ox;
  logic [8:0]   d_oy;

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = small instance, 1 = default instance
  logic [11:0]  mem [2][480][640];
  int           pos [2];
  logic         e_valid [2];
  logic [107:0] e_cd [2];
  int           e_ox [2];
  int           e_oy [2];

  logic [111:0] log_s [$];
  int           d_pulses = 0;

  window_3x3_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(3)) u_small (
    .clk          (clk),
    .reset        (rst_n),
    .pixel_in     (s_pix),
    .pixel_valid  (s_pv),
    .frame_start  (s_fs),
    .color_data   (s_cd),
    .window_valid (s_wv),
    .out_x        (s_ox),
    .out_y        (s_oy)
  );

  window_3x3_gen u_dflt (
    .clk          (clk),
    .reset        (rst_n),
    .pixel_in     (d_pix),
    .pixel_valid  (d_pv),
    .frame_start  (d_fs),
    .color_data   (d_cd),
    .window_valid (d_wv),
    .out_x        (d_ox),
    .out_y        (d_oy)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset(int i);
    pos[i]     = 0;
    e_valid[i] = 1'b0;
    e_cd[i]    = '0;
    e_ox[i]    = 0;
    e_oy[i]    = 0;
  endtask

  // Frame-memory model: store the pixel at its raster position and, for an
  // interior position, read the 3x3 neighbourhood straight out of the frame.
  task automatic model_step(int i, int w, int h, logic pv, logic fs, logic [11:0] pix);
    int x;
    int y;
    int c;
    int r;
    if (!pv) begin
      e_valid[i] = 1'b0;
    end else begin
      if (fs) pos[i] = 0;
      x = pos[i] % w;
      y = pos[i] / w;
      mem[i][y][x] = pix;
      if (x >= 2 && y >= 2) begin
        c = x - 1;
        r = y - 1;
        e_valid[i] = 1'b1;
        e_ox[i]    = c;
        e_oy[i]    = r;
        e_cd[i]    = {mem[i][r][c], mem[i][r][c-1], mem[i][r][c+1],
                      mem[i][r-1][c], mem[i][r+1][c],
                      mem[i][r-1][c-1], mem[i][r-1][c+1],
                      mem[i][r+1][c-1], mem[i][r+1][c+1]};
      end else begin
        e_valid[i] = 1'b0;
      end
      pos[i] = (pos[i] + 1) % (w * h);
    end
  endtask

  initial begin
    model_reset(0);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset(0);
      else        model_step(0, 4, 3, s_pv, s_fs, s_pix);
    end
  end

  initial begin
    model_reset(1);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset(1);
      else        model_step(1, 640, 480, d_pv, d_fs, d_pix);
    end
  end

  // Per-cycle compare, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      chk("s_window_valid", 128'(s_wv), 128'(e_valid[0]));
      chk("s_out_x", 128'(s_ox), 128'(e_ox[0]));
      chk("s_out_y", 128'(s_oy), 128'(e_oy[0]));
      if (e_valid[0]) chk("s_color_data", 128'(s_cd), 128'(e_cd[0]));
      if (s_wv === 1'b1) log_s.push_back({s_cd, s_ox, s_oy});
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("d_window_valid", 128'(d_wv), 128'(e_valid[1]));
      chk("d_out_x", 128'(d_ox), 128'(e_ox[1]));
      chk("d_out_y", 128'(d_oy), 128'(e_oy[1]));
      if (e_valid[1]) chk("d_color_data", 128'(d_cd), 128'(e_cd[1]));
      if (d_wv === 1'b1) d_pulses++;
    end
  end

  // Drive n pixels of the 4x3 test image, pixel = (y<<4)|x
  task automatic s_send(int n, bit gappy, bit fs_first);
    for (int k = 0; k < n; k++) begin
      int p;
      p = k % 12;
      @(negedge clk);
      s_pix = 12'(((p / 4) << 4) | (p % 4));
      s_pv  = 1'b1;
      s_fs  = fs_first && (k == 0);
      if (gappy) begin
        @(negedge clk);
        s_pv = 1'b0;
        s_fs = 1'b0;
      end
    end
    @(negedge clk);
    s_pv = 1'b0;
    s_fs = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  // Check the logged pulse count and the two literal pulses starting at 'first'
  task automatic chk_pulses(string tag, int first, int exp_n);
    logic [111:0] a;
    logic [111:0] b;
    chk({tag, "_pulse_count"}, 128'(log_s.size()), 128'(exp_n));
    a = (log_s.size() > first) ? log_s[first] : '1;
    b = (log_s.size() > first + 1) ? log_s[first+1] : '1;
    chk({tag, "_pulse1"}, 128'(a), 128'({P1, 2'd1, 2'd1}));
    chk({tag, "_pulse2"}, 128'(b), 128'({P2, 2'd2, 2'd1}));
  endtask

  initial begin
    rst_n = 1'b0;
    s_pix = '0;
    s_pv  = 1'b0;
    s_fs  = 1'b0;
    d_pix = '0;
    d_pv  = 1'b0;
    d_fs  = 1'b0;

    #7;
    chk("rst_s_color_data", 128'(s_cd), 128'(0));
    chk("rst_s_window_valid", 128'(s_wv), 128'(0));
    chk("rst_s_out_x", 128'(s_ox), 128'(0));
    chk("rst_s_out_y", 128'(s_oy), 128'(0));
    chk("rst_d_color_data", 128'(d_cd), 128'(0));
    chk("rst_d_window_valid", 128'(d_wv), 128'(0));
    chk("rst_d_out_x", 128'(d_ox), 128'(0));
    chk("rst_d_out_y", 128'(d_oy), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Single continuous 4x3 frame
    log_s.delete();
    s_send(12, 1'b0, 1'b0);
    chk_pulses("single", 0, 2);

    // Same frame with idle cycles between pixels
    log_s.delete();
    s_send(12, 1'b1, 1'b0);
    chk_pulses("gappy", 0, 2);

    // Two frames back to back, no frame_start
    log_s.delete();
    s_send(24, 1'b0, 1'b0);
    chk_pulses("b2b_f1", 0, 4);
    chk_pulses("b2b_f2", 2, 4);

    // Partial frame, then resync with frame_start
    log_s.delete();
    s_send(5, 1'b0, 1'b0);
    s_send(12, 1'b0, 1'b1);
    chk_pulses("resync", 0, 2);

    // Asynchronous reset mid-frame
    s_send(7, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_color_data", 128'(s_cd), 128'(0));
    chk("arst_window_valid", 128'(s_wv), 128'(0));
    chk("arst_out_x", 128'(s_ox), 128'(0));
    chk("arst_out_y", 128'(s_oy), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    log_s.delete();
    s_send(12, 1'b0, 1'b0);
    chk_pulses("after_reset", 0, 2);

    // Random traffic on the small instance, including frame wrap and resyncs
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      s_pv  = ($urandom_range(0, 3) != 0);
      s_fs  = ($urandom_range(0, 9) == 0);
      s_pix = 12'($urandom);
    end
    @(negedge clk);
    s_pv = 1'b0;
    s_fs = 1'b0;

    // Random traffic on the default-size instance; unqualified frame_start
    // pulses must be ignored, one qualified resync at k == 1000
    for (int k = 0; k < 5200; k++) begin
      @(negedge clk);
      d_pv  = (k == 1000) || ($urandom_range(0, 3) != 0);
      d_fs  = (k == 1000) || (!d_pv && ($urandom_range(0, 7) == 0));
      d_pix = 12'($urandom);
    end
    @(negedge clk);
    d_pv = 1'b0;
    d_fs = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("d_pulses_seen", 128'(d_pulses > 0), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_3x3_gen.md
# window_3x3_gen

Streaming 3x3 neighbourhood generator for 12-bit RGB444 pixels in raster order. Two internal line buffers hold the previous two rows; each accepted pixel emits a registered 108-bit window bus in the 9-pixel packing used by the convolution stages (sobel, blur and sharpen). It sits directly upstream of those filters and drives their `color_data` input. Only interior pixels produce windows, so no border padding is required.

## Interface
- IMG_WIDTH, 640, pixels per line (>= 3)
- IMG_HEIGHT, 480, lines per frame (>= 3)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- pixel_in  in  12  RGB444 pixel, {R[11:8], G[7:4], B[3:0]}
- pixel_valid  in  1  pixel_in accepted on this edge when high
- frame_start  in  1  qualified by pixel_valid; marks pixel_in as pixel (0,0)
- color_data  out  108  3x3 window (packing below)
- window_valid  out  1  color_data holds a new interior window
- out_x  out  $clog2(IMG_WIDTH)  centre column of current window
- out_y  out  $clog2(IMG_HEIGHT)  centre row of current window

## Operation
- Counters x (0..IMG_WIDTH-1) and y (0..IMG_HEIGHT-1) give the position of the next accepted pixel.
- On each accept: x increments. At IMG_WIDTH-1, x wraps to 0 and y increments. At (IMG_WIDTH-1, IMG_HEIGHT-1), both wrap to 0.
- frame_start && pixel_valid: the pixel is treated as (0,0) regardless of the counters. Counters then continue at x=1, y=0.
- Line buffers lb0 (row y-1) and lb1 (row y-2) are IMG_WIDTH x 12 with combinational read at address x. On accept: lb1[x] <= lb0[x] and lb0[x] <= pixel_in.
- Three column shift stages, each {top, mid, bot}, shift in {lb1[x], lb0[x], pixel_in} on accept.
- After accept of (x,y), the window holds columns x-2..x and rows y-2..y. The centre is (x-1, y-1).
- Packing, with c = centre column and r = centre row:
  - [107:96] centre (c,r)
  - [95:84] left (c-1,r)
  - [83:72] right (c+1,r)
  - [71:60] up (c,r-1)
  - [59:48] down (c,r+1)
  - [47:36] upleft (c-1,r-1)
  - [35:24] upright (c+1,r-1)
  - [23:12] downleft (c-1,r+1)
  - [11:0] downright (c+1,r+1)
- window_valid <= pixel_valid && x>=2 && y>=2, using the position of the accepted pixel after any frame_start override. Otherwise it is 0.
- out_x <= x-1 and out_y <= y-1 when window_valid is set. They hold otherwise.
- color_data and the shift stages update on every accept, including non-valid positions.
- pixel_valid low: counters, buffers, shift stages, color_data, out_x and out_y hold; window_valid is 0.
- Windows never straddle frames. The first two rows of a frame are suppressed, so stale line-buffer data is never flagged valid.
- Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2).

## Timing
- Reset low, asynchronous: color_data=0, window_valid=0, out_x=0, out_y=0, x=0, y=0, shift stages=0. Line-buffer contents are not reset.
- Reset mid-frame: the next accepted pixel is (0,0). No window is flagged until (2,2) of the new frame.
- Latency: window and flag are registered on the same edge that accepts the completing pixel (x,y), and are visible one cycle later.
- window_valid is a single-cycle pulse per accept. With continuous pixel_valid, it is high for IMG_WIDTH-2 consecutive cycles per line, from line 2 onward.
- Throughput: 1 pixel per clock. There is no backpressure; the downstream stage must accept every cycle.
- frame_start arriving at the natural (0,0) position behaves identically to no frame_start.

## Test plan
Pixel value convention: pixel = (y<<4)|x.

- **Single 4x3 frame** (IMG_WIDTH=4, IMG_HEIGHT=3), 12 continuous pixels -> exactly two window_valid pulses.
  - Pulse 1, after pixel (2,2) is accepted: centre 0x011, left 0x010, right 0x012, up 0x001, down 0x021, upleft 0x000, upright 0x002, downleft 0x020, downright 0x022; out_x=1, out_y=1.
  - Pulse 2, next cycle: centre 0x012, downright 0x023; out_x=2, out_y=1.
- **Gappy input**: same frame with pixel_valid low on alternate cycles -> identical color_data/out_x/out_y sequence. window_valid never high in a cycle following an idle edge.
- **Mid-frame resync**: 5 pixels, then frame_start with the next pixel, then a full 12-pixel frame -> exactly two pulses with the same values as the single-frame scenario.
- **Mid-frame reset**: reset low for 1 cycle after 7 pixels -> all outputs 0 immediately (asynchronous). The following 12-pixel frame gives the two expected pulses.
- **Back-to-back frames** without frame_start -> the second frame yields the same two pulses. No pulse occurs during rows 0-1 of frame 2.
- **Default parameters** (640x480), random pixels -> 304964 pulses per frame; every color_data matches a software 3x3 reference model.
